// File: rtl/rgb2gray_pkg.sv
// Shared types and constants for the RGB->gray stream converter: FSM states,
// weighting modes, component phases and the two coefficient sets.
package rgb2gray_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_R     = 3'd1,
    ST_G     = 3'd2,
    ST_B     = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  typedef enum logic {
    MODE_LUMA = 1'b0,
    MODE_AVG  = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_t;

  localparam int COEF_W = 9;

  // Each set sums to 256, so full-scale input maps to exactly 1.0 before rounding.
  localparam logic [COEF_W-1:0] LUMA_R = 9'd77;
  localparam logic [COEF_W-1:0] LUMA_G = 9'd150;
  localparam logic [COEF_W-1:0] LUMA_B = 9'd29;
  localparam logic [COEF_W-1:0] AVG_R  = 9'd85;
  localparam logic [COEF_W-1:0] AVG_G  = 9'd86;
  localparam logic [COEF_W-1:0] AVG_B  = 9'd85;

  function automatic logic [COEF_W-1:0] coeff_sel(input mode_t mode, input phase_t phase);
    logic [COEF_W-1:0] c;
    c = '0;
    case (phase)
      PH_R:    c = (mode == MODE_AVG) ? AVG_R : LUMA_R;
      PH_G:    c = (mode == MODE_AVG) ? AVG_G : LUMA_G;
      PH_B:    c = (mode == MODE_AVG) ? AVG_B : LUMA_B;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gray_coeff_mac.sv
// Weighted multiply-accumulate over the three colour components of a pixel,
// followed by round-half-up, right shift and saturation to the output width.
module gray_coeff_mac
  import rgb2gray_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             acc_en,
  input  logic [IN_W-1:0]  comp,
  input  phase_t           phase,
  input  mode_t            mode,
  output logic [OUT_W-1:0] result
);

  localparam int ACC_W = IN_W + 9;
  localparam int SH    = 8 + IN_W - OUT_W;

  localparam logic [ACC_W-1:0] HALF    = ACC_W'(1) << (SH - 1);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << OUT_W) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] rounded;

  // The result includes the current beat's product, so the top can register
  // the gray value on the very edge that accepts the B component.
  // NOTE: every always_comb output is given a value before any branch, so no latch can be inferred.
  always_comb begin
    prod    = ACC_W'(comp) * ACC_W'(coeff_sel(mode, phase));
    sum     = acc + prod;
    rounded = (sum + HALF) >> SH;
    result  = (rounded > SAT_MAX) ? OUT_W'(SAT_MAX) : rounded[OUT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/rgb2gray_stream.sv
// Streaming RGB->grayscale converter: R,G,B component beats in, one gray sample
// per pixel out, NUM_PIX pixels per start pulse, done pulse after the last sample.
module rgb2gray_stream
  import rgb2gray_pkg::*;
#(
  parameter int IN_W    = 10,
  parameter int OUT_W   = 8,
  parameter int NUM_PIX = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  comp_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] gray_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t           state;
  mode_t            mode_q;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] pix_cnt_next;
  logic             out_valid_q;
  logic [OUT_W-1:0] gray_q;
  logic             busy_q;
  logic             done_q;

  logic             in_phase;
  logic             beat;
  logic             out_fire;
  logic             start_ok;
  logic             last_pix;
  logic             mac_clear;
  phase_t           phase;
  logic [OUT_W-1:0] mac_result;

  assign out_valid_o = out_valid_q;
  assign gray_o      = gray_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  assign in_phase = (state == ST_R) || (state == ST_G) || (state == ST_B);

  // A pending sample that downstream has not taken blocks new input, which
  // bounds the pipeline to one outstanding gray value.
  assign in_ready_o = in_phase && !(out_valid_q && !out_ready_i);

  assign beat         = in_valid_i && in_ready_o;
  assign out_fire     = out_valid_q && out_ready_i;
  assign start_ok     = (state == ST_IDLE) && start_i && !done_q;
  assign pix_cnt_next = pix_cnt + CNT_W'(1);
  assign last_pix     = !(pix_cnt_next < CNT_W'(NUM_PIX));
  assign mac_clear    = start_ok || (beat && (state == ST_B));

  always_comb begin
    phase = PH_R;
    case (state)
      ST_G:    phase = PH_G;
      ST_B:    phase = PH_B;
      default: phase = PH_R;
    endcase
  end

  gray_coeff_mac #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .clear  (mac_clear),
    .acc_en (beat),
    .comp   (comp_i),
    .phase  (phase),
    .mode   (mode_q),
    .result (mac_result)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_LUMA;
      pix_cnt     <= '0;
      out_valid_q <= 1'b0;
      gray_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A B beat in the same cycle reloads the output register below and wins.
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state   <= ST_R;
            mode_q  <= mode_t'(mode_i);
            pix_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_R: begin
          if (beat) state <= ST_G;
        end
        ST_G: begin
          if (beat) state <= ST_B;
        end
        ST_B: begin
          if (beat) begin
            out_valid_q <= 1'b1;
            gray_q      <= mac_result;
            pix_cnt     <= pix_cnt_next;
            state       <= last_pix ? ST_DRAIN : ST_R;
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed and randomized-gap checks of rgb2gray_stream against hand values and
// a small arithmetic model of the weighted gray conversion.
module tb_rgb2gray_stream;

  localparam int IN_W    = 10;
  localparam int OUT_W   = 8;
  localparam int NUM_PIX = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  comp;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] gray;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  int   got[$];
  int   exp[$];
  int   done_cnt = 0;
  bit   rand_ready = 1'b0;
  logic [IN_W-1:0] px [12];

  rgb2gray_stream #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .NUM_PIX (NUM_PIX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .comp_i      (comp),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .gray_o      (gray),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got.push_back(int'(gray));
      if (done) done_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  function automatic int gray_ref(input logic m, input int r, input int g, input int b);
    int s;
    s = m ? (85 * r + 86 * g + 85 * b) : (77 * r + 150 * g + 29 * b);
    s = (s + 512) >> 10;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic start_frame(input logic m);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [IN_W-1:0] c);
    bit ok = 1'b0;
    int n  = 0;
    in_valid = 1'b1;
    comp     = c;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("beat_timeout", 0, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(posedge clk); #2;
      seen = done;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) check({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk); #2;
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  task automatic push_expected(input logic m);
    for (int p = 0; p < NUM_PIX; p++)
      exp.push_back(gray_ref(m, px[3*p], px[3*p+1], px[3*p+2]));
  endtask

  task automatic compare_samples(input string tag);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_px%0d", tag, i), got[i], exp[i]);
    got.delete();
    exp.delete();
  endtask

  task automatic run_frame(input logic m, input int gap_max, input bit meddle, input string tag);
    start_frame(m);
    for (int i = 0; i < 12; i++) begin
      for (int k = $urandom_range(0, gap_max); k > 0; k--) begin
        @(posedge clk); #1;
      end
      if (meddle) begin
        start = (i >= 1 && i <= 8);
        mode  = ~m;
      end
      send_beat(px[i]);
      if (meddle && i == 5) check({tag, "_busy_mid"}, busy, 1);
    end
    start = 1'b0;
    mode  = m;
    push_expected(m);
    wait_done(tag, 1000);
  endtask

  initial begin
    int base;
    logic [OUT_W-1:0] held;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    in_valid = 1'b0; comp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_gray", gray, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: LUMA 238,238,238 -> 60, registered one cycle after the B beat
    for (int i = 0; i < 12; i++) px[i] = 10'd238;
    px[3] = 10'd100; px[4] = 10'd200; px[5] = 10'd300;
    base = done_cnt;
    start_frame(1'b0);
    check("t1_busy_after_start", busy, 1);
    send_beat(10'd238);
    send_beat(10'd238);
    check("t1_no_early_valid", out_valid, 0);
    send_beat(10'd238);
    check("t1_valid_after_b", out_valid, 1);
    check("t1_gray_60", gray, 60);
    for (int i = 3; i < 12; i++) send_beat(px[i]);
    push_expected(1'b0);
    wait_done("t1", 100);
    compare_samples("t1");
    check("t1_done_count", done_cnt - base, 1);

    // 2: AVG with R only, then LUMA saturation
    px[0] = 10'd1023; px[1] = 10'd0;   px[2] = 10'd0;
    px[3] = 10'd0;    px[4] = 10'd1023; px[5] = 10'd0;
    px[6] = 10'd0;    px[7] = 10'd0;   px[8] = 10'd1023;
    px[9] = 10'd512;  px[10] = 10'd511; px[11] = 10'd1;
    run_frame(1'b1, 0, 1'b0, "t2avg");
    check("t2_avg_r_only_85", (got.size() > 0) ? got[0] : -1, 85);
    compare_samples("t2avg");
    for (int i = 0; i < 12; i++) px[i] = 10'd1023;
    run_frame(1'b0, 0, 1'b0, "t2sat");
    check("t2_sat_255", (got.size() > 0) ? got[0] : -1, 255);
    compare_samples("t2sat");

    // 3: downstream stall of 5 cycles on pixel 2
    for (int i = 0; i < 12; i++) px[i] = IN_W'(40 * i + 7);
    base = done_cnt;
    start_frame(1'b0);
    for (int i = 0; i < 5; i++) send_beat(px[i]);
    out_ready = 1'b0;
    send_beat(px[5]);
    held = gray;
    check("t3_stall_gray", held, gray_ref(1'b0, px[3], px[4], px[5]));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("t3_in_ready_low_c%0d", c), in_ready, 0);
      check($sformatf("t3_gray_stable_c%0d", c), gray, held);
    end
    check("t3_valid_held", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 6; i < 12; i++) send_beat(px[i]);
    push_expected(1'b0);
    wait_done("t3", 100);
    compare_samples("t3");
    check("t3_done_count", done_cnt - base, 1);

    // 4: start and mode toggling mid-frame are ignored
    for (int i = 0; i < 12; i++) px[i] = IN_W'(1000 - 61 * i);
    base = done_cnt;
    run_frame(1'b0, 1, 1'b1, "t4");
    compare_samples("t4");
    check("t4_done_count", done_cnt - base, 1);
    check("t4_idle_after", busy, 0);

    // 5: reset after the G beat aborts the frame
    base = done_cnt;
    start_frame(1'b1);
    send_beat(10'd900);
    send_beat(10'd800);
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_gray", gray, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_no_done_on_abort", done_cnt - base, 0);
    for (int i = 0; i < 12; i++) px[i] = IN_W'(17 + 83 * i);
    run_frame(1'b1, 0, 1'b0, "t5");
    compare_samples("t5");

    // 6: 64 pixels with random input gaps and random downstream ready
    base = done_cnt;
    rand_ready = 1'b1;
    for (int f = 0; f < 64 / NUM_PIX; f++) begin
      for (int i = 0; i < 12; i++) px[i] = IN_W'($urandom_range(0, 1023));
      run_frame(logic'($urandom_range(0, 1)), 3, 1'b0, $sformatf("t6f%0d", f));
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    compare_samples("t6");
    check("t6_done_count", done_cnt - base, 64 / NUM_PIX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
